// File: rtl/uart_tx_pkg.sv
// Shared UART constants: transmitter FSM encodings, MMIO register addresses
// and the status word layout returned on the core's load path.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;

    localparam int unsigned UART_DATA_BITS = 8;

    // Status register: {count[8:0], overflow, full, busy} in the low bits.
    function automatic logic [31:0] uart_status_word(
        input logic       busy,
        input logic       full,
        input logic       ovf,
        input logic [8:0] count
    );
        return {20'd0, count, ovf, full, busy};
    endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter so full and empty
// never alias; pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Flags come from the pre-edge count, so a push while full is refused
    // even when a pop happens on the same edge.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop  & ~empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte writes are queued in a FIFO and
// serialised LSB first; status exposes busy, fill level and sticky overflow.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter  int unsigned CLKS_PER_BIT = 868,
    parameter  int unsigned FIFO_DEPTH   = 16,
    localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [7:0]       wdata,
    input  logic             clr_ovf,
    output logic             full,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic             uart_out
);

    uart_state_t      r_state;
    logic [15:0]      r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_ovf;

    logic [7:0]       w_fifo_dout;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_baud_end;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wen),
        .pop   (w_pop),
        .din   (wdata),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_baud_end = (r_baud == 16'(CLKS_PER_BIT - 1));

    // Popping at the end of STOP chains the next frame with no idle gap.
    always_comb begin
        w_pop = 1'b0;
        unique case (r_state)
            ST_IDLE: w_pop = ~w_fifo_empty;
            ST_STOP: w_pop = w_baud_end & ~w_fifo_empty;
            default: w_pop = 1'b0;
        endcase
    end

    // Line level is registered from the current state, so it trails the
    // state by one edge (write at E -> start bit visible at E+2).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_fifo_dout;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_tx <= 1'b0;
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                ST_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                ST_STOP: begin
                    r_tx <= 1'b1;
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_fifo_dout;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Set wins over clear when a dropped write and clr_ovf share an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (wen & w_fifo_full) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign full       = w_fifo_full;
    assign fifo_count = w_fifo_count;
    assign busy       = (r_state != ST_IDLE) | ~w_fifo_empty;
    assign overflow   = r_ovf;
    assign uart_out   = r_tx;

endmodule
